// File: rtl/game_sequencer_if.sv
// Handshake and status bundle between the snake game sequencer
// and its board-clear engine, snake step engines, renderer and player.
interface game_sequencer_if;
    logic        start;
    logic        clear_req;
    logic        clear_done;
    logic        step1_req;
    logic        step1_done;
    logic        collide1;
    logic        step2_req;
    logic        step2_done;
    logic        collide2;
    logic        draw_en;
    logic [1:0]  stage;
    logic [1:0]  winner;
    logic [7:0]  score1;
    logic [7:0]  score2;
    logic [15:0] frame_count;

    modport master (
        input  start, clear_done,
        input  step1_done, collide1,
        input  step2_done, collide2,
        output clear_req, step1_req, step2_req,
        output draw_en, stage, winner,
        output score1, score2, frame_count
    );

    modport slave (
        output start, clear_done,
        output step1_done, collide1,
        output step2_done, collide2,
        input  clear_req, step1_req, step2_req,
        input  draw_en, stage, winner,
        input  score1, score2, frame_count
    );
endinterface

// File: rtl/game_sequencer.sv
// Two-player snake stage machine: clear, ready, frame tick, ordered steps, resolve.
// Define SNAKE_TWO_PLAYER_EN to step snake 2; otherwise only snake 1 plays.
module game_sequencer #(
    parameter int unsigned TICK_CYCLES = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    game_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_READY,
        S_WAIT,
        S_STEP1,
        S_STEP2,
        S_RESOLVE,
        S_OVER
    } state_t;

    localparam logic [23:0] TICK_LAST = 24'(TICK_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    state_t      w_after1;
    logic        r_start_q;
    logic [23:0] r_tick;
    logic        r_c1;
    logic        r_c2;
    logic        r_clear_req;
    logic        r_step1_req;
    logic        r_draw_en;
    logic [1:0]  r_stage;
    logic [1:0]  r_winner;
    logic [7:0]  r_score1;
    logic [7:0]  r_score2;
    logic [15:0] r_frame;
    logic        w_start_rise;
    logic        w_tick_done;
    logic [1:0]  w_win;

    assign w_start_rise = bus.start & ~r_start_q;
    assign w_tick_done  = (r_tick == TICK_LAST);

`ifdef SNAKE_TWO_PLAYER_EN
    logic r_step2_req;
    assign w_after1      = S_STEP2;
    assign w_win         = {r_c1, r_c2};
    assign bus.step2_req = r_step2_req;
`else
    assign w_after1      = S_RESOLVE;
    assign w_win         = {r_c1, r_c1};
    assign bus.step2_req = 1'b0;
`endif

    assign bus.clear_req   = r_clear_req;
    assign bus.step1_req   = r_step1_req;
    assign bus.draw_en     = r_draw_en;
    assign bus.stage       = r_stage;
    assign bus.winner      = r_winner;
    assign bus.score1      = r_score1;
    assign bus.score2      = r_score2;
    assign bus.frame_count = r_frame;

    function automatic logic [1:0] stage_of(input state_t s);
        unique case (s)
            S_CLEAR: stage_of = 2'd0;
            S_READY: stage_of = 2'd1;
            S_OVER:  stage_of = 2'd3;
            default: stage_of = 2'd2;
        endcase
    endfunction

    // Next-state selection; inputs outside their matching state are ignored.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_CLEAR:   if (bus.clear_done) w_next = S_READY;
            S_READY:   if (w_start_rise) w_next = S_WAIT;
            S_WAIT:    if (w_tick_done) w_next = S_STEP1;
            S_STEP1:   if (bus.step1_done) w_next = w_after1;
            S_STEP2:   if (bus.step2_done) w_next = S_RESOLVE;
            S_RESOLVE: w_next = (r_c1 | r_c2) ? S_OVER : S_WAIT;
            S_OVER:    if (w_start_rise) w_next = S_CLEAR;
            default:   w_next = S_CLEAR;
        endcase
    end

    // State, tick counter, registered outputs, collision latches and scoring.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_CLEAR;
            r_start_q   <= 1'b0;
            r_tick      <= '0;
            r_c1        <= 1'b0;
            r_c2        <= 1'b0;
            r_clear_req <= 1'b1;
            r_step1_req <= 1'b0;
            r_draw_en   <= 1'b0;
            r_stage     <= 2'd0;
            r_winner    <= 2'd0;
            r_score1    <= 8'd0;
            r_score2    <= 8'd0;
            r_frame     <= 16'd0;
`ifdef SNAKE_TWO_PLAYER_EN
            r_step2_req <= 1'b0;
`endif
        end else begin
            r_state     <= w_next;
            r_start_q   <= bus.start;
            r_tick      <= (r_state == S_WAIT && !w_tick_done) ? r_tick + 24'd1 : '0;
            // A request rises one cycle after entry and drops as soon as done is seen.
            r_clear_req <= (r_state == S_CLEAR) && (w_next == S_CLEAR);
            r_step1_req <= (r_state == S_STEP1) && (w_next == S_STEP1);
`ifdef SNAKE_TWO_PLAYER_EN
            r_step2_req <= (r_state == S_STEP2) && (w_next == S_STEP2);
            if (r_state == S_STEP2 && bus.step2_done)
                r_c2 <= bus.collide2;
`endif
            r_draw_en   <= (w_next == S_READY) || (w_next == S_WAIT) || (w_next == S_OVER);
            r_stage     <= stage_of(w_next);
            if (r_state == S_STEP1 && bus.step1_done) begin
                r_c1 <= bus.collide1;
                r_c2 <= 1'b0;
            end
            if (w_next == S_CLEAR && r_state != S_CLEAR) begin
                r_winner <= 2'd0;
                r_frame  <= 16'd0;
            end
            if (r_state == S_RESOLVE) begin
                if (!(r_c1 | r_c2)) begin
                    if (r_frame != 16'hFFFF) r_frame <= r_frame + 16'd1;
                end else begin
                    r_winner <= w_win;
`ifdef SNAKE_TWO_PLAYER_EN
                    if (r_c1 && !r_c2 && r_score2 != 8'hFF) r_score2 <= r_score2 + 8'd1;
                    if (r_c2 && !r_c1 && r_score1 != 8'hFF) r_score1 <= r_score1 + 8'd1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_CYCLES=4 and
// behavioural clear/step engines answering one cycle after request.
module tb_game_sequencer;

`ifdef SNAKE_TWO_PLAYER_EN
    localparam int P   = 11;
    localparam bit TWO = 1'b1;
`else
    localparam int P   = 8;
    localparam bit TWO = 1'b0;
`endif

    typedef struct {
        bit         c1;
        bit         c2;
        bit         over;
        logic [1:0] win;
        logic [7:0] s1;
        logic [7:0] s2;
    } round_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic s_start = 1'b0;
    logic s_cd = 1'b0;
    logic m_s2 = 1'b0;
    logic cfg_c1 = 1'b0;
    logic cfg_c2 = 1'b0;
    logic a_d1 = 1'b0;
    logic a_c1 = 1'b0;
    logic a_d2 = 1'b0;
    logic a_c2 = 1'b0;
    int   n1 = 0;
    int   n2 = 0;
    int   n_req2 = 0;
    int   n_multi = 0;
    int   n_tot = 0;
    int   n_pass = 0;

    game_sequencer_if bus ();

    game_sequencer #(.TICK_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    assign bus.start      = s_start;
    assign bus.clear_done = s_cd;
    assign bus.step1_done = a_d1;
    assign bus.collide1   = a_c1;
    assign bus.step2_done = a_d2 | m_s2;
    assign bus.collide2   = a_c2;

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.step1_req) n1 = n1 + 1;
        else n1 = 0;
        if (bus.step2_req) n2 = n2 + 1;
        else n2 = 0;
        a_d1 = (n1 == 2);
        a_c1 = a_d1 && cfg_c1;
        a_d2 = (n2 == 2);
        a_c2 = a_d2 && cfg_c2;
        if (!reset) begin
            if (bus.step2_req) n_req2 = n_req2 + 1;
            if (32'(bus.clear_req) + 32'(bus.step1_req) + 32'(bus.step2_req) > 1)
                n_multi = n_multi + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time expired, %0d/%0d passed", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot = n_tot + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    task automatic wait_stage(input logic [1:0] s, input int budget, input string nm);
        int n;
        n = 0;
        while (bus.stage !== s && n < budget) begin
            @(negedge clock);
            n = n + 1;
        end
        chk(nm, 32'(bus.stage), 32'(s));
    endtask

    task automatic new_round(input bit hold);
        s_start = 1'b0;
        @(negedge clock);
        s_start = 1'b1;
        @(negedge clock);
        chk("clr_enter", 32'({bus.stage, bus.draw_en, bus.winner, bus.frame_count}), 32'd0);
        if (!hold) s_start = 1'b0;
        @(negedge clock);
        chk("clr_req", 32'(bus.clear_req), 32'd1);
        s_cd = 1'b1;
        @(negedge clock);
        s_cd = 1'b0;
        chk("ready", 32'({bus.stage, bus.draw_en, bus.clear_req}), 32'({2'd1, 1'b1, 1'b0}));
        if (hold) begin
            repeat (3) @(negedge clock);
            chk("hold_start", 32'(bus.stage), 32'd1);
        end
        s_start = 1'b0;
        @(negedge clock);
        s_start = 1'b1;
        @(negedge clock);
        chk("go", 32'(bus.stage), 32'd2);
        s_start = 1'b0;
    endtask

    initial begin
        round_t      rt[3];
        logic [20:0] e;
        logic [7:0]  es1;
        int          p;
        int          n;

`ifdef SNAKE_TWO_PLAYER_EN
        rt[0] = '{c1: 1, c2: 0, over: 1, win: 2'd2, s1: 8'd0, s2: 8'd1};
        rt[1] = '{c1: 1, c2: 1, over: 1, win: 2'd3, s1: 8'd0, s2: 8'd1};
        rt[2] = '{c1: 0, c2: 1, over: 1, win: 2'd1, s1: 8'd1, s2: 8'd1};
`else
        rt[0] = '{c1: 1, c2: 0, over: 1, win: 2'd3, s1: 8'd0, s2: 8'd0};
        rt[1] = '{c1: 1, c2: 1, over: 1, win: 2'd3, s1: 8'd0, s2: 8'd0};
        rt[2] = '{c1: 0, c2: 1, over: 0, win: 2'd0, s1: 8'd0, s2: 8'd0};
`endif

        repeat (2) @(negedge clock);
        chk("rst_clear_req", 32'(bus.clear_req), 32'd1);
        chk("rst_reqs_draw", 32'({bus.step1_req, bus.step2_req, bus.draw_en}), 32'd0);
        chk("rst_stage_win", 32'({bus.stage, bus.winner}), 32'd0);
        chk("rst_counts", {bus.score1, bus.score2, bus.frame_count}, 32'd0);

        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            chk($sformatf("clr_hold%0d", i), 32'({bus.clear_req, bus.stage}), 32'({1'b1, 2'd0}));
        end
        s_cd = 1'b1;
        @(negedge clock);
        s_cd = 1'b0;
        chk("clr_drop", 32'(bus.clear_req), 32'd0);
        chk("ready_draw", 32'({bus.stage, bus.draw_en}), 32'({2'd1, 1'b1}));

        s_start = 1'b1;
        for (int c = 0; c < 2 * P; c++) begin
            @(negedge clock);
            p = c % P;
            e = {(p < 4), (p == 5 || p == 6), (TWO && (p == 8 || p == 9)), 2'd2, 16'(c / P)};
            chk($sformatf("pace%0d", c),
                32'({bus.draw_en, bus.step1_req, bus.step2_req, bus.stage, bus.frame_count}),
                32'(e));
            if (c == 1) s_start = 1'b0;
            if (c == 2) s_start = 1'b1;
            if (c == 3) s_start = 1'b0;
            m_s2 = (c == 5);
        end

        for (int i = 0; i < 3; i++) begin
            cfg_c1 = rt[i].c1;
            cfg_c2 = rt[i].c2;
            if (rt[i].over) begin
                wait_stage(2'd3, 40, $sformatf("rnd%0d_stage", i));
            end else begin
                repeat (30) @(negedge clock);
                chk($sformatf("rnd%0d_stage", i), 32'(bus.stage), 32'd2);
            end
            chk($sformatf("rnd%0d_win", i), 32'(bus.winner), 32'(rt[i].win));
            chk($sformatf("rnd%0d_s1", i), 32'(bus.score1), 32'(rt[i].s1));
            chk($sformatf("rnd%0d_s2", i), 32'(bus.score2), 32'(rt[i].s2));
            if (!rt[i].over) begin
                cfg_c1 = 1'b1;
                wait_stage(2'd3, 40, $sformatf("rnd%0d_end", i));
            end
            cfg_c1 = 1'b0;
            cfg_c2 = 1'b0;
            new_round(i == 0);
        end

        cfg_c1 = !TWO;
        cfg_c2 = TWO;
        for (int k = 0; k < 256; k++) begin
            wait_stage(2'd3, 40, $sformatf("sat%0d_stage", k));
            es1 = TWO ? ((k + 2 > 255) ? 8'd255 : 8'(k + 2)) : 8'd0;
            chk($sformatf("sat%0d_s1", k), 32'(bus.score1), 32'(es1));
            new_round(1'b0);
        end
        chk("sat_s2", 32'(bus.score2), TWO ? 32'd1 : 32'd0);
        cfg_c1 = 1'b0;
        cfg_c2 = 1'b0;

        n = 0;
        while (bus.step1_req !== 1'b1 && n < 40) begin
            @(negedge clock);
            n = n + 1;
        end
        chk("mid_req_seen", 32'(bus.step1_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'({bus.step1_req, bus.step2_req}), 32'd0);
        chk("mid_rst_stage", 32'({bus.stage, bus.clear_req, bus.draw_en}), 32'({2'd0, 1'b1, 1'b0}));
        chk("mid_rst_score", 32'(bus.score1), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        chk("one_req", n_multi, 32'd0);
        chk("req2_seen", 32'(n_req2 != 0), 32'(TWO));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
